// File: rtl/srt4_sequencer_if.sv
// Operand/result handshake and srt4 core bus bundle for srt4_sequencer.
// slave: the sequencer side; master: client plus divider core side.
interface srt4_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             timeout;
    logic             div_by_zero;
    logic [WIDTH-1:0] inbus;
    logic             beginSignal;
    logic [WIDTH-1:0] outbus;
    logic             endSignal;

    modport slave (
        input  op_valid, dividend, divisor, res_ready, outbus, endSignal,
        output op_ready, res_valid, quotient, remainder, timeout, div_by_zero,
               inbus, beginSignal
    );

    modport master (
        output op_valid, dividend, divisor, res_ready, outbus, endSignal,
        input  op_ready, res_valid, quotient, remainder, timeout, div_by_zero,
               inbus, beginSignal
    );
endinterface

// File: rtl/srt4_sequencer.sv
// Serialises an operand pair onto the srt4 core bus, collects the result and guards it with a watchdog.
// Optional SRT4_SEQ_DIVZERO_EN: short-circuit zero divisors without starting the core.
module srt4_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_b,
    srt4_sequencer_if.slave   bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_CAP_R, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] inbus_q, inbus_d;
    logic             timeout_q, timeout_d;
    logic             op_ready_q, op_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             begin_q, begin_d;
`ifdef SRT4_SEQ_DIVZERO_EN
    logic             dbz_q, dbz_d;
`endif

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        timeout_d   = timeout_q;
        inbus_d     = '0;
`ifdef SRT4_SEQ_DIVZERO_EN
        dbz_d       = dbz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    divisor_d = bus.divisor;
                    state_d   = S_LOAD_A;
                    inbus_d   = bus.dividend;
`ifdef SRT4_SEQ_DIVZERO_EN
                    if (bus.divisor == '0) begin
                        state_d     = S_DONE;
                        inbus_d     = '0;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end
`endif
                end
            end
            S_LOAD_A: begin
                inbus_d = divisor_q;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                inbus_d = divisor_q;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completing core wins over an expiring watchdog.
                if (bus.endSignal) begin
                    quotient_d = bus.outbus;
                    state_d    = S_CAP_R;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    timeout_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    inbus_d = divisor_q;
                end
            end
            S_CAP_R: begin
                remainder_d = bus.outbus;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    timeout_d = 1'b0;
`ifdef SRT4_SEQ_DIVZERO_EN
                    dbz_d     = 1'b0;
`endif
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        op_ready_d  = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
        begin_d     = (state_d == S_LOAD_A);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            inbus_q     <= '0;
            timeout_q   <= 1'b0;
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            begin_q     <= 1'b0;
`ifdef SRT4_SEQ_DIVZERO_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            inbus_q     <= inbus_d;
            timeout_q   <= timeout_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            begin_q     <= begin_d;
`ifdef SRT4_SEQ_DIVZERO_EN
            dbz_q       <= dbz_d;
`endif
        end
    end

    assign bus.op_ready    = op_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.timeout     = timeout_q;
    assign bus.inbus       = inbus_q;
    assign bus.beginSignal = begin_q;
`ifdef SRT4_SEQ_DIVZERO_EN
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_srt4_sequencer.sv
// Scoreboard bench for srt4_sequencer with a behavioural srt4 core of programmable latency.
module tb_srt4_sequencer;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 16;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         to;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    logic stray_req = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_begin = 0;
    int   core_lat = 5;
    exp_t exp_q[$];
    exp_t mon_e;

    srt4_sequencer_if #(.WIDTH(W)) bus();

    srt4_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit to);
        exp_t e;
        e.to = to;
        e.dz = 1'b0;
        if (to) begin
            e.q = '0;
            e.r = '0;
        end else if (b == '0) begin
            e.q = '1;
            e.r = a;
`ifdef SRT4_SEQ_DIVZERO_EN
            e.dz = 1'b1;
`endif
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Behavioural core: dividend with beginSignal, divisor next cycle, result after core_lat (-1 = never).
    logic [W-1:0] c_a, c_b;
    int c_phase, c_cnt;
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            c_phase       <= 0;
            c_cnt         <= 0;
            c_a           <= '0;
            c_b           <= '0;
            bus.endSignal <= 1'b0;
            bus.outbus    <= '0;
        end else begin
            bus.endSignal <= stray_req;
            if (bus.beginSignal) begin
                c_a     <= bus.inbus;
                c_phase <= 1;
            end else begin
                case (c_phase)
                    1: begin
                        c_b     <= bus.inbus;
                        c_cnt   <= 0;
                        c_phase <= 2;
                    end
                    2: begin
                        if (core_lat >= 0 && c_cnt == core_lat) begin
                            bus.endSignal <= 1'b1;
                            bus.outbus    <= (c_b == '0) ? '1 : c_a / c_b;
                            c_phase       <= 3;
                        end else begin
                            c_cnt <= c_cnt + 1;
                        end
                    end
                    3: begin
                        bus.outbus <= (c_b == '0) ? c_a : c_a % c_b;
                        c_phase    <= 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) if (bus.beginSignal === 1'b1) n_begin++;

    // Result monitor: compare on every cycle that ends in a result handshake.
    always @(negedge clk) begin
        #1;
        if (rst_b === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("res_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_quotient", 32'(bus.quotient), 32'(mon_e.q));
                check("res_remainder", 32'(bus.remainder), 32'(mon_e.r));
                check("res_timeout", 32'(bus.timeout), 32'(mon_e.to));
                check("res_div_by_zero", 32'(bus.div_by_zero), 32'(mon_e.dz));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge (cycle 1).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit to);
        int n;
        n = 0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.op_valid = 1'b1;
        while (bus.op_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("op_ready_never", 32'd0, 32'd1);
        exp_q.push_back(model(a, b, to));
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int start, output int n);
        n = start;
        while (bus.res_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check({tag, "_no_result"}, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: got hang expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n, b0, k;
        rst_b        = 1'b0;
        bus.op_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_op_ready", 32'(bus.op_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_begin", 32'(bus.beginSignal), 32'd0);
        check("rst_inbus", 32'(bus.inbus), 32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        check("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // Basic divide 211/6 with cycle-accurate bus checks.
        bus.res_ready = 1'b1;
        core_lat = 5;
        b0 = n_begin;
        send(8'd211, 8'd6, 1'b0);
        bus.op_valid = 1'b0;
        check("basic_begin_c1", 32'(bus.beginSignal), 32'd1);
        check("basic_inbus_c1", 32'(bus.inbus), 32'd211);
        check("basic_op_ready_c1", 32'(bus.op_ready), 32'd0);
        @(negedge clk);
        check("basic_begin_c2", 32'(bus.beginSignal), 32'd0);
        check("basic_inbus_c2", 32'(bus.inbus), 32'd6);
        @(negedge clk);
        check("basic_inbus_c3", 32'(bus.inbus), 32'd6);
        wait_valid("basic", 3, n);
        check("basic_latency", 32'(n), 32'd11);
        check("basic_begin_count", 32'(n_begin - b0), 32'd1);
        @(negedge clk);

        // Result backpressure 50/7.
        bus.res_ready = 1'b0;
        send(8'd50, 8'd7, 1'b0);
        bus.op_valid = 1'b0;
        wait_valid("bp", 1, n);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {14'd0, bus.res_valid, bus.op_ready, bus.quotient, bus.remainder},
                  {14'd0, 1'b1, 1'b0, 8'd7, 8'd1});
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.res_valid), 32'd0);
        check("bp_release_ready", 32'(bus.op_ready), 32'd1);

        // Watchdog: core never answers.
        core_lat = -1;
        send(8'd9, 8'd3, 1'b1);
        bus.op_valid = 1'b0;
        wait_valid("to", 1, n);
        check("to_latency", 32'(n), 32'd19);
        @(negedge clk);
        check("to_flag_cleared", 32'(bus.timeout), 32'd0);

        // endSignal on the last watchdog cycle: normal capture.
        core_lat = 14;
        send(8'd77, 8'd5, 1'b0);
        bus.op_valid = 1'b0;
        wait_valid("edge", 1, n);
        check("edge_latency", 32'(n), 32'd20);
        @(negedge clk);

        // Divide by zero 100/0.
        core_lat = 5;
        b0 = n_begin;
        send(8'd100, 8'd0, 1'b0);
        bus.op_valid = 1'b0;
        wait_valid("dz", 1, n);
        repeat (3) @(negedge clk);
`ifdef SRT4_SEQ_DIVZERO_EN
        check("dz_latency", 32'(n), 32'd1);
        check("dz_begin_count", 32'(n_begin - b0), 32'd0);
`else
        check("dz_latency", 32'(n), 32'd11);
        check("dz_begin_count", 32'(n_begin - b0), 32'd1);
`endif

        // Asynchronous reset in WAIT, then 200/7.
        core_lat = 10;
        send(8'd200, 8'd7, 1'b0);
        bus.op_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        check("mid_rst_op_ready", 32'(bus.op_ready), 32'd1);
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_begin", 32'(bus.beginSignal), 32'd0);
        check("mid_rst_inbus", 32'(bus.inbus), 32'd0);
        check("mid_rst_quotient", 32'(bus.quotient), 32'd0);
        check("mid_rst_remainder", 32'(bus.remainder), 32'd0);
        check("mid_rst_timeout", 32'(bus.timeout), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        send(8'd200, 8'd7, 1'b0);
        bus.op_valid = 1'b0;
        wait_valid("post_rst", 1, n);
        check("post_rst_latency", 32'(n), 32'd16);
        @(negedge clk);

        // Stray endSignal while idle.
        stray_req = 1'b1;
        @(negedge clk);
        stray_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_idle", {29'd0, bus.op_ready, bus.res_valid, bus.beginSignal},
                  {29'd0, 1'b1, 1'b0, 1'b0});
        end

        // Back-to-back with op_valid held high.
        core_lat = 3;
        b0 = n_begin;
        send(8'd255, 8'd16, 1'b0);
        send(8'd13, 8'd13, 1'b0);
        send(8'd7, 8'd200, 1'b0);
        bus.op_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("b2b_drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("b2b_begin_count", 32'(n_begin - b0), 32'd3);
        check("b2b_idle", 32'(bus.op_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/srt4_sequencer.md
# srt4_sequencer

Operand/result sequencer sitting directly in front of the `srt4` divider core. It accepts a dividend/divisor pair over a valid/ready handshake and serialises it onto the core's 8-bit `inbus` with the `beginSignal` pulse. It then waits for `endSignal`, collects quotient and remainder from `outbus`, and returns them over a second valid/ready handshake. It also guards the core with a completion watchdog.

## Interface
- `WIDTH`, 8: operand/result width; must equal the `srt4` bus width.
- `TIMEOUT`, 64: max cycles in WAIT before abort; ≥ 2.
- `clk` in 1: single clock, rising-edge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `op_valid` in 1: operand pair valid.
- `op_ready` out 1: sequencer can accept operands.
- `dividend` in WIDTH: dividend, sampled on accept.
- `divisor` in WIDTH: divisor, sampled on accept.
- `res_valid` out 1: result registers valid.
- `res_ready` in 1: consumer accepts result.
- `quotient` out WIDTH: captured quotient.
- `remainder` out WIDTH: captured remainder.
- `timeout` out 1: result aborted by watchdog; valid with `res_valid`.
- `div_by_zero` out 1: divisor was zero; valid with `res_valid`.
- `inbus` out WIDTH: to `srt4.inbus`.
- `beginSignal` out 1: to `srt4.beginSignal`.
- `outbus` in WIDTH: from `srt4.outbus`.
- `endSignal` in 1: from `srt4.endSignal`.

## Operation
- **States:** IDLE, LOAD_A, LOAD_B, WAIT, CAP_R, DONE. Outputs are Moore-decoded from the registered state and registered operand/result holders.
- **IDLE**
  - `op_ready`=1.
  - On `op_valid`&&`op_ready`: latch `dividend`/`divisor` and go to LOAD_A.
- **LOAD_A** (1 cycle): `beginSignal`=1, `inbus`=dividend. Next state is LOAD_B.
- **LOAD_B** (1 cycle): `beginSignal`=0, `inbus`=divisor. Clear the watchdog counter. Next state is WAIT.
- **WAIT**
  - `inbus` holds the divisor and the counter increments each cycle.
  - On a cycle with `endSignal`=1: `quotient`←`outbus`, then go to CAP_R.
  - If the counter reaches TIMEOUT−1 with no `endSignal`: `quotient`=`remainder`=0, `timeout`=1, then go to DONE.
  - `endSignal` wins over a simultaneous timeout.
- **CAP_R** (1 cycle): `remainder`←`outbus`. Next state is DONE.
- **DONE**
  - `res_valid`=1; `quotient`/`remainder`/flags are held stable.
  - On `res_ready`=1: go to IDLE and clear the flags on the same edge.
- **`inbus` outside LOAD_A..WAIT:** 0.
- **Stray `endSignal`:** ignored outside WAIT.
- **Acceptance:** no new operands are accepted until the result is consumed. There is no pipelining.
- **Reset (`rst_b`=0), any time including mid-division:**
  - State → IDLE.
  - `op_ready`=1; `res_valid`=`beginSignal`=`timeout`=`div_by_zero`=0.
  - `inbus`=`quotient`=`remainder`=0.
  - The counter is cleared.
  - The core is reset by the same `rst_b`, so no drain is needed.

## Timing
- **Accept edge** = cycle 0.
- **Cycle 1:** LOAD_A, `beginSignal`=1.
- **Cycle 2:** LOAD_B.
- **Cycle 3 onward:** WAIT.
- **End of division:** with `endSignal` seen in cycle E, the remainder is captured in E+1 and `res_valid` rises in cycle E+2.
- **`op_ready`:** low from cycle 1 through the DONE handshake edge. The next accept is possible 1 cycle after the result handshake.
- **Timeout:** `res_valid` rises exactly TIMEOUT cycles after entering WAIT.

## Configuration
- **`SRT4_SEQ_DIVZERO_EN` defined:**
  - A latched divisor of 0 skips LOAD_A..CAP_R and goes from IDLE straight to DONE on the cycle after accept.
  - Result: `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1.
  - `beginSignal` never pulses.
- **`SRT4_SEQ_DIVZERO_EN` undefined:**
  - A zero divisor is sent to the core like any other divisor; the result is whatever the core returns, or a timeout.
  - `div_by_zero` is tied to 0.

## Test plan
- **Basic divide:** dividend=211, divisor=6 with the core model.
  - `beginSignal` is high for exactly 1 cycle with `inbus`=211, then `inbus`=6.
  - Result `quotient`=35, `remainder`=1, `timeout`=0.
- **Result backpressure:** `res_ready`=0 for 10 cycles after `res_valid`.
  - Outputs are held stable and `op_ready` stays 0.
  - On `res_ready`=1: `res_valid` drops next cycle and `op_ready`=1.
- **Timeout:** core stub never raises `endSignal`, TIMEOUT=16.
  - `res_valid` rises 16 cycles after WAIT entry, with `timeout`=1 and `quotient`=`remainder`=0.
  - `endSignal` and timeout on the same cycle: a normal capture occurs.
- **Divide by zero:** dividend=100, divisor=0.
  - With the macro: no `beginSignal`; one cycle after accept, `quotient`=255, `remainder`=100, `div_by_zero`=1.
  - Without the macro: `beginSignal` pulses and `div_by_zero`=0.
- **Reset mid-operation:** assert `rst_b`=0 asynchronously in WAIT, between clock edges.
  - All outputs reach their reset values immediately.
  - A subsequent 200/7 completes with `quotient`=28, `remainder`=4.
- **Back-to-back:** `op_valid` held high with 3 operand pairs and `res_ready` tied high.
  - Each pair is accepted exactly once, and results appear in order.
  - A stray `endSignal` in IDLE is ignored.
